// File: rtl/pcs_fifo_wr_arb.sv
// Write-side arbiter for the PCS 25G clock-crossing FIFO.
// Two sources share one FIFO write port through a single hold register.
module pcs_fifo_wr_arb #(
    parameter int WIDTH      = 192,
    parameter int STARVE_MAX = 8,
    parameter int STALL_MAX  = 1024
) (
    input  logic             clkw,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             prio_mode,
    input  logic             stall_clr,
    input  logic [WIDTH-1:0] s0_data,
    input  logic             s0_valid,
    output logic             s0_ready,
    input  logic [WIDTH-1:0] s1_data,
    input  logic             s1_valid,
    output logic             s1_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_datavalid,
    input  logic             m_idle,
    output logic             stall_err
);

    logic [WIDTH-1:0] hold_data;
    logic             hold_valid;
    logic             last_grant;
    logic [7:0]       starve_cnt;
    logic [15:0]      stall_cnt;

    logic xfer;
    logic hold_free;
    logic blocked;
    logic starve_hit;
    logic g0;
    logic g1;

    assign xfer       = enable & hold_valid & m_idle;
    assign hold_free  = ~hold_valid | xfer;
    assign blocked    = enable & hold_valid & ~m_idle;
    assign starve_hit = (starve_cnt == 8'(STARVE_MAX));

    assign m_datavalid = xfer;
    assign m_data      = hold_data;
    assign s0_ready    = g0;
    assign s1_ready    = g1;

    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (enable && hold_free) begin
            unique case (1'b1)
                (s0_valid && !s1_valid): g0 = 1'b1;
                (s1_valid && !s0_valid): g1 = 1'b1;
                (s0_valid && s1_valid): begin
                    // last_grant=1 means s1 won last time
                    if (prio_mode) begin
                        g1 = starve_hit;
                        g0 = ~starve_hit;
                    end else begin
                        g0 = last_grant;
                        g1 = ~last_grant;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clkw or negedge reset_n) begin
        if (!reset_n) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
            last_grant <= 1'b1;
        end else if (g0 || g1) begin
            hold_data  <= g1 ? s1_data : s0_data;
            hold_valid <= 1'b1;
            last_grant <= g1;
        end else if (xfer) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clkw or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (enable && prio_mode) begin
            if (g1 || !s1_valid) begin
                starve_cnt <= '0;
            end else if (g0 && !starve_hit) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clkw or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            stall_err <= 1'b0;
        end else begin
            if (!blocked) begin
                stall_cnt <= '0;
            end else if (stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            // a set on this cycle overrides a coincident clear
            if (blocked && stall_cnt >= 16'(STALL_MAX - 1)) begin
                stall_err <= 1'b1;
            end else if (stall_clr) begin
                stall_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pcs_fifo_wr_arb.sv
// Randomized and directed bench for pcs_fifo_wr_arb.
// A queue-based model predicts every output each cycle.
module tb_pcs_fifo_wr_arb;

    localparam int W  = 64;
    localparam int SM = 3;
    localparam int TM = 16;

    logic         clkw;
    logic         reset_n;
    logic         enable;
    logic         prio_mode;
    logic         stall_clr;
    logic [W-1:0] s0_data;
    logic         s0_valid;
    logic         s0_ready;
    logic [W-1:0] s1_data;
    logic         s1_valid;
    logic         s1_ready;
    logic [W-1:0] m_data;
    logic         m_datavalid;
    logic         m_idle;
    logic         stall_err;

    pcs_fifo_wr_arb #(
        .WIDTH(W),
        .STARVE_MAX(SM),
        .STALL_MAX(TM)
    ) dut (
        .clkw(clkw),
        .reset_n(reset_n),
        .enable(enable),
        .prio_mode(prio_mode),
        .stall_clr(stall_clr),
        .s0_data(s0_data),
        .s0_valid(s0_valid),
        .s0_ready(s0_ready),
        .s1_data(s1_data),
        .s1_valid(s1_valid),
        .s1_ready(s1_ready),
        .m_data(m_data),
        .m_datavalid(m_datavalid),
        .m_idle(m_idle),
        .stall_err(stall_err)
    );

    initial clkw = 1'b0;
    always #5 clkw = ~clkw;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] mq[$];
    bit m_last1;
    int m_starve;
    int m_brun;
    bit m_err;

    bit e_g0, e_g1, e_dv;
    logic a_r0, a_r1, a_dv, a_err;
    logic [W-1:0] a_data;

    task automatic chk(input string n, input logic [W-1:0] a,
                       input logic [W-1:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_last1  = 1'b1;
        m_starve = 0;
        m_brun   = 0;
        m_err    = 1'b0;
    endfunction

    task automatic compare();
        bit busy, free;
        busy = (mq.size() != 0);
        e_dv = enable && busy && m_idle;
        free = !busy || e_dv;
        e_g0 = 1'b0;
        e_g1 = 1'b0;
        if (enable && free) begin
            if (s0_valid && s1_valid) begin
                if (prio_mode) e_g1 = (m_starve == SM);
                else           e_g1 = !m_last1;
                e_g0 = !e_g1;
            end else begin
                e_g0 = s0_valid;
                e_g1 = s1_valid;
            end
        end
        a_r0   = s0_ready;
        a_r1   = s1_ready;
        a_dv   = m_datavalid;
        a_err  = stall_err;
        a_data = m_data;
        chk("m_datavalid", W'(a_dv), W'(e_dv));
        chk("s0_ready", W'(a_r0), W'(e_g0));
        chk("s1_ready", W'(a_r1), W'(e_g1));
        chk("stall_err", W'(a_err), W'(m_err));
        if (e_dv) chk("m_data", a_data, mq[0]);
    endtask

    task automatic update();
        bit blk;
        blk = enable && (mq.size() != 0) && !m_idle;
        if (e_dv) void'(mq.pop_front());
        if (e_g0) mq.push_back(s0_data);
        if (e_g1) mq.push_back(s1_data);
        if (e_g0 || e_g1) m_last1 = e_g1;
        if (prio_mode && enable) begin
            if (e_g1 || !s1_valid) m_starve = 0;
            else if (e_g0 && m_starve < SM) m_starve++;
        end
        m_brun = blk ? m_brun + 1 : 0;
        m_err  = (blk && m_brun >= TM) || (m_err && !stall_clr);
    endtask

    task automatic cycle();
        #3;
        compare();
        @(posedge clkw);
        update();
        #1;
    endtask

    task automatic do_reset();
        s0_valid  = 1'b0;
        s1_valid  = 1'b0;
        stall_clr = 1'b0;
        reset_n   = 1'b0;
        #1;
        model_reset();
        chk("rst_dv", W'(m_datavalid), '0);
        chk("rst_r0", W'(s0_ready), '0);
        chk("rst_r1", W'(s1_ready), '0);
        chk("rst_data", m_data, '0);
        chk("rst_err", W'(stall_err), '0);
        @(posedge clkw);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] wlog[$];
        int n, first, last, c0, c1;
        logic [31:0] pat;

        enable    = 1'b1;
        prio_mode = 1'b0;
        m_idle    = 1'b1;
        s0_data   = '0;
        s1_data   = '0;
        do_reset();

        // s0 streaming
        n = 0; first = -1; last = -1;
        for (int k = 0; k < 40 && wlog.size() < 10; k++) begin
            s0_valid = (n < 10);
            s0_data  = W'(32'hD0 + n);
            cycle();
            if (a_r0) n++;
            if (a_dv) begin
                wlog.push_back(a_data);
                if (first < 0) first = k;
                last = k;
            end
        end
        s0_valid = 1'b0;
        chk("s0_writes", W'(wlog.size()), W'(10));
        chk("s0_span", W'(last - first), W'(9));
        for (int k = 0; k < wlog.size(); k++)
            chk("s0_order", wlog[k], W'(32'hD0 + k));

        // round robin
        do_reset();
        s0_valid = 1'b1; s1_valid = 1'b1;
        n = 0; c0 = 0; c1 = 0; pat = '0;
        for (int k = 0; k < 60 && n < 20; k++) begin
            s0_data = W'(32'h1000 + k);
            s1_data = W'(32'h2000 + k);
            cycle();
            if (a_r0) begin c0++; n++; end
            if (a_r1) begin c1++; pat[n] = 1'b1; n++; end
        end
        chk("rr_c0", W'(c0), W'(10));
        chk("rr_c1", W'(c1), W'(10));
        chk("rr_pat", W'(pat), W'(32'h000AAAAA));

        // priority with starvation guard
        do_reset();
        prio_mode = 1'b1;
        s0_valid = 1'b1; s1_valid = 1'b1;
        n = 0; pat = '0;
        for (int k = 0; k < 30 && n < 8; k++) begin
            s0_data = W'(32'h3000 + k);
            s1_data = W'(32'h4000 + k);
            cycle();
            if (a_r1) pat[n] = 1'b1;
            if (a_r0 || a_r1) n++;
        end
        chk("pr_pat", W'(pat), W'(32'h88));
        s0_valid = 1'b0; s1_valid = 1'b0;
        prio_mode = 1'b0;

        // full boundary
        do_reset();
        s0_valid = 1'b1; s0_data = W'(32'hA1);
        cycle();
        s0_data = W'(32'hA2);
        m_idle = 1'b0;
        c0 = 0; c1 = 0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (a_dv) c0++;
            if (a_r0 || a_r1) c1++;
        end
        chk("full_dv", W'(c0), '0);
        chk("full_rdy", W'(c1), '0);
        m_idle = 1'b1;
        cycle();
        chk("full_ret_dv", W'(a_dv), W'(1));
        chk("full_ret_data", a_data, W'(32'hA1));
        s0_valid = 1'b0;
        cycle();
        chk("full_next", a_data, W'(32'hA2));
        cycle();
        chk("full_nodup", W'(a_dv), '0);

        // stall watchdog
        do_reset();
        m_idle = 1'b0;
        s0_valid = 1'b1; s0_data = W'(32'hB1);
        cycle();
        s0_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (k == 16) chk("stall_c16", W'(a_err), '0);
            if (k == 17) chk("stall_c17", W'(a_err), W'(1));
        end
        chk("stall_hold", W'(a_err), W'(1));
        stall_clr = 1'b1;
        cycle();
        stall_clr = 1'b0;
        cycle();
        chk("stall_reset", W'(a_err), W'(1));
        m_idle = 1'b1;
        stall_clr = 1'b1;
        cycle();
        stall_clr = 1'b0;
        cycle();
        chk("stall_clear", W'(a_err), '0);
        cycle();

        // async reset mid-transfer
        s0_valid = 1'b1; s0_data = W'(32'hC1);
        cycle();
        s0_data = W'(32'hC2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_dv", W'(m_datavalid), '0);
        chk("arst_err", W'(stall_err), '0);
        model_reset();
        s0_valid = 1'b0;
        @(posedge clkw);
        #1;
        reset_n = 1'b1;
        s0_valid = 1'b1; s1_valid = 1'b1;
        cycle();
        chk("arst_first_s0", W'(a_r0), W'(1));
        s0_valid = 1'b0; s1_valid = 1'b0;
        cycle();

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            if (k % 250 == 0) prio_mode = 1'($urandom_range(0, 1));
            enable    = ($urandom_range(0, 9) != 0);
            s0_valid  = 1'($urandom_range(0, 1));
            s1_valid  = enable ? 1'($urandom_range(0, 1)) : 1'b1;
            if ((k / 250) % 2 == 1) m_idle = ($urandom_range(0, 3) == 0);
            else                    m_idle = ($urandom_range(0, 3) != 0);
            stall_clr = ($urandom_range(0, 19) == 0);
            s0_data   = {$urandom, $urandom};
            s1_data   = {$urandom, $urandom};
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
